pl_stage_buf: RTL and testbench
===============================

// Module: pl_stage_buf
// PURPOSE
//   Generic, parametrised pipeline stage register with valid/ready handshake, hazard stall and flush.
//   Replaces the hand-written per-stage registers (decode->execute, execute->memory, memory->writeback).
//   Carries a DATA field (operands, PC, instruction) and a CTRL field (decoded control). CTRL is zeroed on bubble/flush.
//   An optional skid entry registers in_ready so long ready chains are cut.
// PARAMETERS
//   DATA_W   224  width of datapath payload (7 x 32-bit words for the D->E stage)
//   CTRL_W   11   width of control payload (result_src 2, alu_ctrl 4, alu_src, regwrite, branch, jalr, jump)
//   RST_DATA 0    when 1, DATA is also zeroed on bubble; when 0, DATA holds its last value on bubble
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   flush      in   1       hazard-unit clear: kill held and incoming contents
//   stall      in   1       hazard-unit hold: freeze stage, accept and retire nothing
//   in_valid   in   1       upstream holds a valid instruction
//   in_ready   out  1       stage can accept this cycle
//   in_data    in   DATA_W  upstream datapath payload
//   in_ctrl    in   CTRL_W  upstream control payload
//   out_valid  out  1       output entry valid
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  registered datapath payload
//   out_ctrl   out  CTRL_W  registered control payload (all-zero = bubble)
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ctrl=0, skid entry empty; in_ready=0 during reset cycle, 1 the cycle after.
//   - in_fire = in_valid & in_ready. out_fire = out_valid & out_ready & ~stall. Downstream counts only out_fire.
//   - Priority per edge: reset > flush > stall > normal.
//   - flush: out_valid=0, out_ctrl=0, out_data=0, skid emptied; in_data not captured even if in_valid=1. in_ready=0 that cycle.
//   - stall: all state holds; in_ready=0; out_valid/out_data/out_ctrl unchanged (registered, no comb path from stall).
//   - Base mode: in_ready = ~stall & ~flush & (~out_valid | out_ready). Latency 1 cycle in->out.
//     - On in_fire: out_* <= in_*, out_valid <= 1.
//     - On in_ready & ~in_valid: out_valid <= 0, out_ctrl <= 0 (bubble); out_data zeroed only if RST_DATA=1.
//     - On ~in_ready (out held by backpressure): all outputs hold.
//   - No width arithmetic; payloads pass through bit-exact. Simultaneous flush+stall = flush.
// CONFIGURATION
//   PL_STAGE_SKID_EN defined: second (skid) entry added.
//     - in_ready = ~skid_valid_q & ~stall & ~flush; no comb path from out_ready to in_ready.
//     - in_fire while main full and ~out_fire -> payload goes to skid; next out_fire moves skid -> main (1-cycle).
//     - Order preserved (main always older than skid); latency 1 cycle when empty, throughput 1/cycle.
//     - flush empties both entries; stall freezes both.
//   PL_STAGE_SKID_EN undefined: single entry, base-mode in_ready as above; skid logic absent.
// STRUCTURE
//   pl_pkg: localparams for CTRL field layout (CTRL_RESULT_SRC_LSB, CTRL_ALU_CTRL_LSB, ... CTRL_W=11),
//     DE_DATA_W=224, and CTRL_BUBBLE = '0.
//   Sub-module pl_stage_slot: one {valid, ctrl, data} register with load / clear / bubble controls;
//     instantiated once (main) or twice (main + skid).
// TESTING
//   1. reset=1 for 2 cycles with in_valid=1, in_data=A -> out_valid=0, out_ctrl=0, out_data=0; in_ready=1 after release.
//   2. Stream D0..D7, out_ready=1 -> out_data=Dn exactly 1 cycle after in_fire, no gaps, order kept.
//   3. out_valid=1 (D0), stall=1 for 3 cycles with in_valid=1 (D1) -> out_data=D0 held, in_ready=0, D1 taken 1 cycle after stall drops.
//   4. flush=1 with stall=1 and in_valid=1 (ctrl=0x7FF) -> next cycle out_valid=0, out_ctrl=0, out_data=0.
//   5. in_valid=0 for 1 cycle mid-stream, ctrl=0x155 before -> bubble: out_valid=0, out_ctrl=0; data per RST_DATA.
//   6. SKID_EN: out_ready=0 while D0,D1 sent -> D0 main, D1 skid, in_ready=0; out_ready=1 -> D0 then D1 on consecutive cycles.

Source files
------------

// File: rtl/pl_pkg.sv
// ---------------------------------------------------------------------------
// pl_pkg
//   Shared definitions for the pipeline stage registers.
//   - Control field layout (bit positions inside the CTRL payload).
//   - Default decode->execute datapath width.
//   - Bubble encoding for the control field.
//   - Slot operation enum used between pl_stage_buf and pl_stage_slot.
//   - pack_ctrl helper to build a CTRL word from its named fields.
// ---------------------------------------------------------------------------
package pl_pkg;

  // Decode->execute payload: 7 x 32-bit words (operands, PCs, immediate, ...)
  localparam int DE_DATA_W = 224;

  // Control field layout, LSB first
  localparam int CTRL_JUMP_LSB       = 0;
  localparam int CTRL_JALR_LSB       = 1;
  localparam int CTRL_BRANCH_LSB     = 2;
  localparam int CTRL_REGWRITE_LSB   = 3;
  localparam int CTRL_ALU_SRC_LSB    = 4;
  localparam int CTRL_ALU_CTRL_LSB   = 5;
  localparam int CTRL_ALU_CTRL_W     = 4;
  localparam int CTRL_RESULT_SRC_LSB = 9;
  localparam int CTRL_RESULT_SRC_W   = 2;
  localparam int CTRL_W              = 11;

  // An all-zero control word is a bubble: no writeback, no branch, no jump
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // What a storage slot does on the next clock edge
  typedef enum logic [1:0] {
    SLOT_HOLD   = 2'd0,
    SLOT_LOAD   = 2'd1,
    SLOT_BUBBLE = 2'd2,
    SLOT_CLEAR  = 2'd3
  } slot_op_e;

  // Named view of the control word (field order matches the bit layout)
  typedef struct packed {
    logic [CTRL_RESULT_SRC_W-1:0] result_src;
    logic [CTRL_ALU_CTRL_W-1:0]   alu_ctrl;
    logic                         alu_src;
    logic                         regwrite;
    logic                         branch;
    logic                         jalr;
    logic                         jump;
  } ctrl_t;

  // Build a control word from named fields using the layout constants
  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t c);
    logic [CTRL_W-1:0] w;
    w = CTRL_BUBBLE;
    w[CTRL_JUMP_LSB]     = c.jump;
    w[CTRL_JALR_LSB]     = c.jalr;
    w[CTRL_BRANCH_LSB]   = c.branch;
    w[CTRL_REGWRITE_LSB] = c.regwrite;
    w[CTRL_ALU_SRC_LSB]  = c.alu_src;
    w[CTRL_ALU_CTRL_LSB +: CTRL_ALU_CTRL_W]     = c.alu_ctrl;
    w[CTRL_RESULT_SRC_LSB +: CTRL_RESULT_SRC_W] = c.result_src;
    return w;
  endfunction

endpackage

// File: rtl/pl_stage_slot.sv
// ---------------------------------------------------------------------------
// pl_stage_slot
//   One {valid, ctrl, data} storage entry of a pipeline stage.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   synchronous active-high reset (clears everything)
//     op       in   HOLD / LOAD / BUBBLE / CLEAR for the next edge
//     ld_data  in   datapath payload to load
//     ld_ctrl  in   control payload to load
//     valid    out  entry holds a valid instruction
//     data     out  registered datapath payload
//     ctrl     out  registered control payload (zero when not valid)
//   RST_DATA selects whether a bubble also zeroes the datapath payload.
// ---------------------------------------------------------------------------
module pl_stage_slot #(
  parameter int DATA_W   = pl_pkg::DE_DATA_W,
  parameter int CTRL_W   = pl_pkg::CTRL_W,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  pl_pkg::slot_op_e     op,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [CTRL_W-1:0]    ld_ctrl,
  output logic                 valid,
  output logic [DATA_W-1:0]    data,
  output logic [CTRL_W-1:0]    ctrl
);
  import pl_pkg::*;

  // Single register bank. CLEAR (flush) always wipes data; BUBBLE only
  // wipes data when RST_DATA is set, otherwise the stale payload is kept
  // to avoid toggling the wide datapath on every empty cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else begin
      case (op)
        SLOT_LOAD: begin
          valid <= 1'b1;
          ctrl  <= ld_ctrl;
          data  <= ld_data;
        end
        SLOT_BUBBLE: begin
          valid <= 1'b0;
          ctrl  <= '0;
          if (RST_DATA) data <= '0;
        end
        SLOT_CLEAR: begin
          valid <= 1'b0;
          ctrl  <= '0;
          data  <= '0;
        end
        default: begin
          valid <= valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/pl_stage_buf.sv
// ---------------------------------------------------------------------------
// pl_stage_buf
//   Generic pipeline stage register with valid/ready handshake, hazard
//   stall and flush. Carries a DATA payload and a CTRL payload; CTRL is
//   zeroed whenever the stage holds a bubble.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     flush      in   kill held and incoming contents
//     stall      in   freeze the stage, accept and retire nothing
//     in_valid   in   upstream offers an instruction
//     in_ready   out  stage accepts this cycle
//     in_data    in   upstream datapath payload  [DATA_W]
//     in_ctrl    in   upstream control payload   [CTRL_W]
//     out_valid  out  output entry valid
//     out_ready  in   downstream accepts
//     out_data   out  registered datapath payload [DATA_W]
//     out_ctrl   out  registered control payload  [CTRL_W], zero = bubble
//   Build option:
//     PL_STAGE_SKID_EN  adds a second (skid) entry so in_ready no longer
//                       depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module pl_stage_buf #(
  parameter int DATA_W   = pl_pkg::DE_DATA_W,
  parameter int CTRL_W   = pl_pkg::CTRL_W,
  parameter bit RST_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);
  import pl_pkg::*;

  slot_op_e          main_op;
  logic [DATA_W-1:0] main_ld_data;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic              in_fire;

  assign in_fire = in_valid & in_ready;

`ifdef PL_STAGE_SKID_EN
  slot_op_e          skid_op;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              out_fire;

  assign out_fire = out_valid & out_ready & ~stall;

  // Ready depends only on registered skid state and hazard inputs, which
  // cuts the combinational ready chain from downstream.
  assign in_ready = ~reset & ~flush & ~stall & ~skid_valid;

  // Slot sequencing. The skid entry is only ever filled while main is
  // occupied, so main is always the older instruction. When main retires
  // the skid entry (if any) moves up; otherwise a new input or a bubble
  // takes its place.
  always_comb begin
    main_op      = SLOT_HOLD;
    skid_op      = SLOT_HOLD;
    main_ld_data = in_data;
    main_ld_ctrl = in_ctrl;
    if (flush) begin
      main_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (!stall) begin
      if (!out_valid) begin
        main_op = in_fire ? SLOT_LOAD : SLOT_BUBBLE;
      end else if (out_fire) begin
        if (skid_valid) begin
          main_op      = SLOT_LOAD;
          main_ld_data = skid_data;
          main_ld_ctrl = skid_ctrl;
          skid_op      = SLOT_BUBBLE;
        end else begin
          main_op = in_fire ? SLOT_LOAD : SLOT_BUBBLE;
        end
      end else if (in_fire) begin
        skid_op = SLOT_LOAD;
      end
    end
  end

  pl_stage_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .op      (skid_op),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );
`else
  // Single entry: accept whenever the held entry is empty or leaving.
  assign in_ready = ~reset & ~flush & ~stall & (~out_valid | out_ready);

  // in_ready already excludes flush and stall, so the later branches only
  // see the normal handshake. Ready without valid inserts a bubble.
  always_comb begin
    main_op      = SLOT_HOLD;
    main_ld_data = in_data;
    main_ld_ctrl = in_ctrl;
    if (flush) begin
      main_op = SLOT_CLEAR;
    end else if (in_fire) begin
      main_op = SLOT_LOAD;
    end else if (in_ready) begin
      main_op = SLOT_BUBBLE;
    end
  end
`endif

  pl_stage_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_DATA (RST_DATA)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .op      (main_op),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .valid   (out_valid),
    .data    (out_data),
    .ctrl    (out_ctrl)
  );

endmodule

// File: tb/tb_pl_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pl_stage_buf
//   Self-checking bench for pl_stage_buf. Accepted inputs are pushed into
//   an expected-results queue and popped/compared whenever the stage
//   retires an entry. Scenario tasks cover reset, streaming, stall, flush,
//   bubbles, the skid entry (when PL_STAGE_SKID_EN is defined) and a
//   random back-to-back run with backpressure and stalls.
// ---------------------------------------------------------------------------
module tb_pl_stage_buf;

  localparam int DW = 224;
  localparam int CW = 11;
  localparam bit RD = 1'b0;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;

  entry_t exp_q[$];
  entry_t e;
  int     n_cmp = 0;
  int     n_err = 0;

  pl_stage_buf #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .RST_DATA (RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct payload per index, every 32-bit word different
  function automatic logic [DW-1:0] mk_data(input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int w = 0; w < 7; w++) d[w*32 +: 32] = 32'hA500_0000 ^ (32'(n) << 8) ^ 32'(w);
    return d;
  endfunction

  // Non-zero control word per index (zero would look like a bubble)
  function automatic logic [CW-1:0] mk_ctrl(input int n);
    logic [CW-1:0] c;
    c = CW'(n * 37 + 3);
    if (c == '0) c = 11'h001;
    return c;
  endfunction

  // Drive one cycle's inputs (called just after a falling edge), then settle
  task automatic set_in(input logic v, input int n, input logic ordy, input logic st, input logic fl);
    in_valid  = v;
    in_data   = mk_data(n);
    in_ctrl   = mk_ctrl(n);
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("[TB] FAIL reset_ctrl: got %h, required 0", out_ctrl); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("[TB] FAIL reset_data: got %h, required 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_in_ready: got %b, required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL release_valid: got %b, required 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, i, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL stream_ready[%0d]: got %b, required 1", i, in_ready); end
      if (i > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stream_gap[%0d]: got %b, required 1", i, out_valid); end
      end
      if (out_valid && out_ready && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL stream_out: got ctrl=%h with empty queue, required none", out_ctrl); end
        else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL stream_out: got ctrl=%h data=%h, required ctrl=%h data=%h", out_ctrl, out_data, e.ctrl, e.data); end end
      end
      if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      @(negedge clk);
    end
    set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stream_last_valid: got %b, required 1", out_valid); end
    if (out_valid && out_ready && !stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL stream_last: got ctrl=%h with empty queue, required none", out_ctrl); end
      else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL stream_last: got ctrl=%h data=%h, required ctrl=%h data=%h", out_ctrl, out_data, e.ctrl, e.data); end end
    end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stream_end_valid: got %b, required 0", out_valid); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("[TB] FAIL stream_queue: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    set_in(1'b1, 20, 1'b0, 1'b0, 1'b0);
    if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 21, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall_ready[%0d]: got %b, required 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== mk_data(20) || out_ctrl !== mk_ctrl(20)) begin
        n_err++; $display("[TB] FAIL stall_hold[%0d]: got v=%b ctrl=%h data=%h, required v=1 ctrl=%h data=%h", k, out_valid, out_ctrl, out_data, mk_ctrl(20), mk_data(20));
      end
      @(negedge clk);
    end
    set_in(1'b1, 21, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL stall_release_ready: got %b, required 1", in_ready); end
    if (out_valid && out_ready && !stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL stall_out0: got ctrl=%h with empty queue, required none", out_ctrl); end
      else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL stall_out0: got ctrl=%h data=%h, required ctrl=%h data=%h", out_ctrl, out_data, e.ctrl, e.data); end end
    end
    if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    @(negedge clk);
    set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stall_d1_valid: got %b, required 1", out_valid); end
    if (out_valid && out_ready && !stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL stall_out1: got ctrl=%h with empty queue, required none", out_ctrl); end
      else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL stall_out1: got ctrl=%h data=%h, required ctrl=%h data=%h", out_ctrl, out_data, e.ctrl, e.data); end end
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    set_in(1'b1, 30, 1'b0, 1'b0, 1'b0);
    if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    @(negedge clk);
    set_in(1'b1, 31, 1'b0, 1'b1, 1'b1);
    in_ctrl = 11'h7FF;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL flush_in_ready: got %b, required 0", in_ready); end
    exp_q.delete();
    @(negedge clk);
    set_in(1'b0, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("[TB] FAIL flush_ctrl: got %h, required 0", out_ctrl); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("[TB] FAIL flush_data: got %h, required 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_after_ready: got %b, required 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_bubble();
    logic [DW-1:0] bub_data;
    set_in(1'b1, 40, 1'b1, 1'b0, 1'b0);
    in_ctrl = 11'h155;
    #1;
    if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    @(negedge clk);
    set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
    if (out_valid && out_ready && !stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL bubble_pre: got ctrl=%h with empty queue, required none", out_ctrl); end
      else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL bubble_pre: got ctrl=%h data=%h, required ctrl=%h data=%h", out_ctrl, out_data, e.ctrl, e.data); end end
    end
    @(negedge clk);
    set_in(1'b1, 41, 1'b1, 1'b0, 1'b0);
    bub_data = RD ? '0 : mk_data(40);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bubble_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("[TB] FAIL bubble_ctrl: got %h, required 0", out_ctrl); end
    n_cmp++; if (out_data !== bub_data) begin n_err++; $display("[TB] FAIL bubble_data: got %h, required %h", out_data, bub_data); end
    if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    @(negedge clk);
    set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bubble_resume_valid: got %b, required 1", out_valid); end
    if (out_valid && out_ready && !stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL bubble_post: got ctrl=%h with empty queue, required none", out_ctrl); end
      else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL bubble_post: got ctrl=%h data=%h, required ctrl=%h data=%h", out_ctrl, out_data, e.ctrl, e.data); end end
    end
    @(negedge clk);
  endtask

`ifdef PL_STAGE_SKID_EN
  task automatic test_skid();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 50 + i, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL skid_fill_ready[%0d]: got %b, required 1", i, in_ready); end
      if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      @(negedge clk);
    end
    set_in(1'b1, 52, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL skid_full_ready: got %b, required 0", in_ready); end
    n_cmp++; if (out_data !== mk_data(50)) begin n_err++; $display("[TB] FAIL skid_main_data: got %h, required %h", out_data, mk_data(50)); end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL skid_drain_valid[%0d]: got %b, required 1", i, out_valid); end
      if (out_valid && out_ready && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL skid_drain[%0d]: got ctrl=%h with empty queue, required none", i, out_ctrl); end
        else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL skid_drain[%0d]: got ctrl=%h data=%h, required ctrl=%h data=%h", i, out_ctrl, out_data, e.ctrl, e.data); end end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL skid_empty_valid: got %b, required 0", out_valid); end
    // Fill both entries, then flush: both must empty
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 53 + i, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    set_in(1'b0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_err++; $display("[TB] FAIL skid_flush_out: got v=%b ctrl=%h, required v=0 ctrl=0", out_valid, out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL skid_flush_ready: got %b, required 1", in_ready); end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 3) != 0, 200 + i, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'b0);
      if (out_valid && out_ready && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL b2b_out[%0d]: got ctrl=%h with empty queue, required none", i, out_ctrl); end
        else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL b2b_out[%0d]: got ctrl=%h data=%h, required ctrl=%h data=%h", i, out_ctrl, out_data, e.ctrl, e.data); end end
      end
      if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 0, 1'b1, 1'b0, 1'b0);
      if (out_valid && out_ready && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("[TB] FAIL b2b_drain[%0d]: got ctrl=%h with empty queue, required none", i, out_ctrl); end
        else begin e = exp_q.pop_front(); if ({out_ctrl, out_data} !== e) begin n_err++; $display("[TB] FAIL b2b_drain[%0d]: got ctrl=%h data=%h, required ctrl=%h data=%h", i, out_ctrl, out_data, e.ctrl, e.data); end end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("[TB] FAIL b2b_queue: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    stall     = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk_data(100);
    in_ctrl   = 11'h7FF;
    out_ready = 1'b1;
    $display("[TB] starting pl_stage_buf bench");
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
`ifdef PL_STAGE_SKID_EN
    test_skid();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
